// File: rtl/alu_op_sequencer.sv
// Initiator for a combinational ALU: latches a request, holds the ALU inputs for an
// opcode-dependent settle time, then captures result/carry into a response register.
module alu_op_sequencer #(
  parameter int          N         = 32,
  parameter logic [3:0]  BASE_WAIT = 4'd0,
  parameter logic [3:0]  MUL_WAIT  = 4'd2,
  parameter logic [3:0]  MOD_WAIT  = 4'd4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_opcode,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  output logic [2:0]   alu_opcode,
  output logic [N-1:0] alu_operandA,
  output logic [N-1:0] alu_operandB,
  input  logic [N-1:0] alu_result,
  input  logic         alu_carryout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_carry,
  output logic [2:0]   rsp_opcode,
  output logic         rsp_divzero,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_MOD = 3'b011;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [N-1:0] rsp_result_q, rsp_result_d;
  logic         rsp_carry_q, rsp_carry_d;
  logic [2:0]   rsp_opcode_q, rsp_opcode_d;
  logic         rsp_divzero_q, rsp_divzero_d;

  function automatic logic [3:0] settle_cycles(input logic [2:0] op);
    logic [3:0] w;
    case (op)
      OP_MUL:  w = MUL_WAIT;
      OP_MOD:  w = MOD_WAIT;
      default: w = BASE_WAIT;
    endcase
    return w;
  endfunction

  // State, counter, ALU-drive and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      alu_op_q      <= 3'd0;
      alu_a_q       <= {N{1'b0}};
      alu_b_q       <= {N{1'b0}};
      rsp_result_q  <= {N{1'b0}};
      rsp_carry_q   <= 1'b0;
      rsp_opcode_q  <= 3'd0;
      rsp_divzero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      rsp_result_q  <= rsp_result_d;
      rsp_carry_q   <= rsp_carry_d;
      rsp_opcode_q  <= rsp_opcode_d;
      rsp_divzero_q <= rsp_divzero_d;
    end
  end

  // Next-state: accept, settle countdown, capture, response handshake.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    rsp_result_d  = rsp_result_q;
    rsp_carry_d   = rsp_carry_q;
    rsp_opcode_d  = rsp_opcode_q;
    rsp_divzero_d = rsp_divzero_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          alu_op_d = req_opcode;
          alu_a_d  = req_a;
          alu_b_d  = req_b;
          // A modulo by zero never consults the ALU; respond immediately.
          if ((req_opcode == OP_MOD) && (req_b == {N{1'b0}})) begin
            cnt_d         = 4'd0;
            rsp_result_d  = {N{1'b0}};
            rsp_carry_d   = 1'b0;
            rsp_opcode_d  = OP_MOD;
            rsp_divzero_d = 1'b1;
            state_d       = ST_DONE;
          end else begin
            cnt_d   = settle_cycles(req_opcode);
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ST_WAIT;
        end else begin
          rsp_result_d  = alu_result;
          rsp_carry_d   = alu_carryout;
          rsp_opcode_d  = alu_op_q;
          rsp_divzero_d = 1'b0;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign rsp_valid    = (state_q == ST_DONE);
  assign alu_opcode   = alu_op_q;
  assign alu_operandA = alu_a_q;
  assign alu_operandB = alu_b_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_opcode   = rsp_opcode_q;
  assign rsp_divzero  = rsp_divzero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer with a behavioural combinational ALU.
module tb_alu_op_sequencer;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_opcode = 3'd0;
  logic [N-1:0] req_a = 32'd0;
  logic [N-1:0] req_b = 32'd0;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_operandA;
  logic [N-1:0] alu_operandB;
  logic [N-1:0] alu_result;
  logic         alu_carryout;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [N-1:0] rsp_result;
  logic         rsp_carry;
  logic [2:0]   rsp_opcode;
  logic         rsp_divzero;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] res;
    logic        carry;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_op_sequencer #(.N(N), .BASE_WAIT(4'd0), .MUL_WAIT(4'd2), .MOD_WAIT(4'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_opcode(rsp_opcode), .rsp_divzero(rsp_divzero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Division by zero returns a poison value so a wrongly captured ALU output is visible.
  function automatic logic [32:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] r;
    case (op)
      3'b000:  r = {1'b0, a} + {1'b0, b};
      3'b001:  r = {1'b0, a} - {1'b0, b};
      3'b010:  r = {1'b0, a * b};
      3'b011:  r = (b == 32'd0) ? {1'b1, 32'hDEADBEEF} : {1'b0, a % b};
      3'b100:  r = {1'b0, a & b};
      3'b101:  r = {1'b0, a[15:0], b[15:0]};
      3'b110:  r = {1'b0, a >> b[4:0]};
      default: r = {1'b0, a << b[4:0]};
    endcase
    return r;
  endfunction

  function automatic int settle_of(input logic [2:0] op);
    case (op)
      3'b010:  return 2;
      3'b011:  return 4;
      default: return 0;
    endcase
  endfunction

  always_comb {alu_carryout, alu_result} = alu_model(alu_opcode, alu_operandA, alu_operandB);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    exp_t        e;
    logic [32:0] m;
    int          cyc;
    chk("ready_before_accept", req_ready, 32'd1);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
    m     = alu_model(op, a, b);
    e.op  = op;
    e.dz  = (op == 3'b011) && (b == 32'd0);
    e.res = e.dz ? 32'd0 : m[31:0];
    e.carry = e.dz ? 1'b0 : m[32];
    e.lat = e.dz ? 0 : settle_of(op) + 1;
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_opcode = 3'($urandom_range(0, 7));
    chk("ready_after_accept", req_ready, 32'd0);
    chk("busy_after_accept", busy, 32'd1);
    chk("alu_opcode", alu_opcode, op);
    chk("alu_a", alu_operandA, a);
    chk("alu_b", alu_operandB, b);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
      req_a = $urandom; req_b = $urandom;
      chk("busy_in_wait", busy, 32'd1);
      chk("alu_a_stable", alu_operandA, a);
      chk("alu_b_stable", alu_operandB, b);
    end
    chk("latency", cyc, e.lat);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_opcode = 3'b100; req_a = 32'h1234_5678; req_b = 32'hFFFF_0000;
      tick();
      chk("hold_valid", rsp_valid, 32'd1);
      chk("hold_result", rsp_result, e.res);
      chk("hold_no_accept", alu_opcode, op);
    end
    e = sb.pop_front();
    chk("rsp_result", rsp_result, e.res);
    chk("rsp_carry", rsp_carry, e.carry);
    chk("rsp_opcode", rsp_opcode, e.op);
    chk("rsp_divzero", rsp_divzero, e.dz);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("valid_dropped", rsp_valid, 32'd0);
    chk("ready_after_rsp", req_ready, 32'd1);
    chk("idle_not_busy", busy, 32'd0);
    chk("rsp_result_kept", rsp_result, e.res);
    chk("alu_held_in_idle", alu_operandA, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_req_ready", req_ready, 32'd1);
    chk("rst_busy", busy, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_alu_opcode", alu_opcode, 32'd0);
    chk("rst_alu_a", alu_operandA, 32'd0);
    chk("rst_alu_b", alu_operandB, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_flags", {rsp_carry, rsp_divzero, rsp_opcode}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(3'b010, 32'd7, 32'd6, 0);
    run_op(3'b011, 32'd17, 32'd0, 0);
    run_op(3'b011, 32'd17, 32'd5, 0);
    run_op(3'b001, 32'd10, 32'd3, 10);
    run_op(3'b100, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    run_op(3'b101, 32'hAAAA_1111, 32'hBBBB_2222, 0);
    run_op(3'b110, 32'h8000_0000, 32'd31, 0);
    run_op(3'b111, 32'd1, 32'd4, 0);
    run_op(3'b001, 32'd3, 32'd10, 2);

    // Abort a modulo mid-settle with an asynchronous reset.
    req_valid = 1'b1; req_opcode = 3'b011; req_a = 32'd100; req_b = 32'd7;
    tick();
    req_valid = 1'b0;
    tick();
    chk("abort_busy", busy, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", req_ready, 32'd1);
    chk("abort_busy_clr", busy, 32'd0);
    chk("abort_alu", {alu_opcode, alu_operandA[15:0], alu_operandB[12:0]}, 32'd0);
    chk("abort_rsp", {rsp_valid, rsp_carry, rsp_divzero, rsp_opcode, rsp_result[25:0]}, 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_no_rsp", rsp_valid, 32'd0);
    end
    chk("abort_ready_after", req_ready, 32'd1);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
